backprop_core: RTL and testbench

Training-path gradient engine for the neural-burning accelerator. It holds the per-layer error vector (delta) and computes weight-update vectors row by row from the derivative vectors supplied by the forward datapath. It also accumulates the error to propagate to the previous layer. Update vectors are pushed onto an internal LIFO, tagged with layer and row, and popped on demand by the weight-memory writer.

---
 rtl/backprop_core.sv | 150 +++++++++++++++
 tb/tb_backprop_core.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/backprop_core.sv
`default_nettype none
// ============================================================================
// backprop_core : per-layer delta/error engine with a tagged LIFO of updates
// Revision      : 1.0
// ============================================================================
module backprop_core #(
  parameter int max_layer_size = 4,
  parameter int data_size      = 16,
  parameter int size           = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [data_size-1:0]      learning_rate,
  input  logic                      active_train,
  input  logic                      start_new_layer,
  input  logic                      is_last_layer,
  input  logic [31:0]               current_input_layer,
  input  logic [31:0]               current_input_row,
  input  logic [size*data_size-1:0] diff_cost,
  input  logic [size*data_size-1:0] diff_act,
  input  logic [size*data_size-1:0] diff_start,
  input  logic [size*data_size-1:0] diff_dense,
  input  logic                      read_update_data,
  output logic                      is_update_weight,
  output logic [31:0]               update_weight_layer,
  output logic [31:0]               update_weight_row,
  output logic [size*data_size-1:0] update_weight_value
);

  localparam int DW    = data_size;
  localparam int VW    = size * data_size;
  localparam int DEPTH = max_layer_size * size;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FRAC  = 8;

  localparam logic [CW-1:0]          DEPTH_C = CW'(DEPTH);
  localparam logic [31:0]            SIZE_C  = 32'(size);
  localparam logic signed [2*DW:0]   SAT_MAX = {{(DW+2){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [2*DW:0]   SAT_MIN = {{(DW+2){1'b1}}, {(DW-1){1'b0}}};

  function automatic logic signed [DW-1:0] sat(input logic signed [2*DW:0] v);
    logic signed [DW-1:0] r;
    if (v > SAT_MAX)      r = {1'b0, {(DW-1){1'b1}}};
    else if (v < SAT_MIN) r = {1'b1, {(DW-1){1'b0}}};
    else                  r = v[DW-1:0];
    return r;
  endfunction

  function automatic logic signed [DW-1:0] mul(input logic signed [DW-1:0] a,
                                               input logic signed [DW-1:0] b);
    logic signed [2*DW-1:0] p;
    p = $signed({{DW{a[DW-1]}}, a}) * $signed({{DW{b[DW-1]}}, b});
    p = p >>> FRAC;
    return sat({p[2*DW-1], p});
  endfunction

  function automatic logic signed [DW-1:0] add(input logic signed [DW-1:0] a,
                                               input logic signed [DW-1:0] b);
    logic signed [2*DW:0] s;
    s = $signed({{(DW+1){a[DW-1]}}, a}) + $signed({{(DW+1){b[DW-1]}}, b});
    return sat(s);
  endfunction

  logic signed [DW-1:0] delta      [size];
  logic signed [DW-1:0] err_acc    [size];
  logic signed [DW-1:0] delta_load [size];
  logic signed [DW-1:0] err_next   [size];
  logic signed [DW-1:0] sel_delta;
  logic [VW-1:0]        grad_vec;

  logic [CW-1:0] count;
  logic [CW-1:0] count_m1;
  logic [IW-1:0] top_idx;
  logic [IW-1:0] wr_idx;
  logic          row_ok;
  logic          push;
  logic          pop_ok;
  logic          push_ok;

  logic [31:0]   mem_layer [DEPTH];
  logic [31:0]   mem_row   [DEPTH];
  logic [VW-1:0] mem_val   [DEPTH];

  always_comb begin
    sel_delta = '0;
    grad_vec  = '0;
    for (int k = 0; k < size; k++) begin
      if (current_input_row == 32'(k)) sel_delta = delta[k];
    end
    row_ok   = (current_input_row < SIZE_C);
    push     = active_train & ~start_new_layer & row_ok;
    pop_ok   = read_update_data & (count != '0);
    // A pop frees the top slot, so a push into a full stack can still land there.
    push_ok  = push & (pop_ok | (count != DEPTH_C));
    count_m1 = count - CW'(1);
    top_idx  = count_m1[IW-1:0];
    wr_idx   = pop_ok ? top_idx : count[IW-1:0];
    for (int j = 0; j < size; j++) begin
      grad_vec[(size-j)*DW-1 -: DW] =
        mul(learning_rate, mul(sel_delta, diff_start[(size-j)*DW-1 -: DW]));
      err_next[j]   = add(err_acc[j], mul(diff_dense[(size-j)*DW-1 -: DW], sel_delta));
      delta_load[j] = mul(is_last_layer ? diff_cost[(size-j)*DW-1 -: DW] : err_acc[j],
                          diff_act[(size-j)*DW-1 -: DW]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count               <= '0;
      is_update_weight    <= 1'b0;
      update_weight_layer <= '0;
      update_weight_row   <= '0;
      update_weight_value <= '0;
      for (int i = 0; i < size; i++) begin
        delta[i]   <= '0;
        err_acc[i] <= '0;
      end
    end else begin
      is_update_weight <= pop_ok;
      if (pop_ok) begin
        update_weight_layer <= mem_layer[top_idx];
        update_weight_row   <= mem_row[top_idx];
        update_weight_value <= mem_val[top_idx];
      end
      if (pop_ok && !push_ok)      count <= count - CW'(1);
      else if (push_ok && !pop_ok) count <= count + CW'(1);
      if (active_train) begin
        if (start_new_layer) begin
          for (int i = 0; i < size; i++) begin
            delta[i]   <= delta_load[i];
            err_acc[i] <= '0;
          end
        end else if (row_ok) begin
          for (int i = 0; i < size; i++) err_acc[i] <= err_next[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_layer[wr_idx] <= current_input_layer;
      mem_row[wr_idx]   <= current_input_row;
      mem_val[wr_idx]   <= grad_vec;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_backprop_core.sv
`default_nettype none
// ============================================================================
// tb_backprop_core : randomized scoreboard bench with a queue-based LIFO model
// Revision         : 1.0
// ============================================================================
module tb_backprop_core;

  localparam int DEPTH = 12;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] learning_rate;
  logic        active_train, start_new_layer, is_last_layer, read_update_data;
  logic [31:0] current_input_layer, current_input_row;
  logic [47:0] diff_cost, diff_act, diff_start, diff_dense;
  logic        is_update_weight;
  logic [31:0] update_weight_layer, update_weight_row;
  logic [47:0] update_weight_value;

  backprop_core #(.max_layer_size(4), .data_size(16), .size(3)) dut (
    .clk                 (clk),
    .reset               (reset),
    .learning_rate       (learning_rate),
    .active_train        (active_train),
    .start_new_layer     (start_new_layer),
    .is_last_layer       (is_last_layer),
    .current_input_layer (current_input_layer),
    .current_input_row   (current_input_row),
    .diff_cost           (diff_cost),
    .diff_act            (diff_act),
    .diff_start          (diff_start),
    .diff_dense          (diff_dense),
    .read_update_data    (read_update_data),
    .is_update_weight    (is_update_weight),
    .update_weight_layer (update_weight_layer),
    .update_weight_row   (update_weight_row),
    .update_weight_value (update_weight_value)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] layer;
    logic [31:0] row;
    logic [47:0] val;
    int          cyc;
  } exp_t;

  exp_t stack_m[$];
  exp_t exp_q[$];
  int   m_delta[3];
  int   m_err[3];
  int   checks = 0, errors = 0, edge_count = 0;

  int          lr;
  int          cost[3], act[3], start[3], dense[3];
  bit          at, snl, last, rd;
  int unsigned layer_in, row_in;

  function automatic int sat16(longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  function automatic int fmul(int a, int b);
    longint p;
    p = longint'(a) * longint'(b);
    return sat16(p >>> 8);
  endfunction

  function automatic int s16(logic [15:0] x);
    return int'($signed(x));
  endfunction

  function automatic int rnd16();
    logic [15:0] t;
    t = 16'($urandom);
    return s16(t);
  endfunction

  function automatic logic [47:0] pack3(int a, int b, int c);
    return {a[15:0], b[15:0], c[15:0]};
  endfunction

  // Reference behaviour for the edge about to happen, using the current inputs.
  function automatic void model_step();
    exp_t ent;
    int   d;
    int   g[3];
    int   nd[3];
    if (rd && stack_m.size() > 0) begin
      ent = stack_m[$];
      ent.cyc = edge_count + 1;
      exp_q.push_back(ent);
      void'(stack_m.pop_back());
    end
    if (at && snl) begin
      for (int i = 0; i < 3; i++) nd[i] = fmul(last ? cost[i] : m_err[i], act[i]);
      m_delta = nd;
      m_err   = '{0, 0, 0};
    end else if (at && row_in < 3) begin
      d = m_delta[row_in];
      for (int j = 0; j < 3; j++) begin
        g[j]     = fmul(lr, fmul(d, start[j]));
        m_err[j] = sat16(longint'(m_err[j]) + longint'(fmul(dense[j], d)));
      end
      ent.layer = layer_in;
      ent.row   = row_in;
      ent.val   = pack3(g[0], g[1], g[2]);
      ent.cyc   = 0;
      if (stack_m.size() < DEPTH) stack_m.push_back(ent);
    end
  endfunction

  task automatic tick();
    learning_rate       = 16'(lr);
    active_train        = at;
    start_new_layer     = snl;
    is_last_layer       = last;
    read_update_data    = rd;
    current_input_layer = layer_in;
    current_input_row   = row_in;
    diff_cost           = pack3(cost[0], cost[1], cost[2]);
    diff_act            = pack3(act[0], act[1], act[2]);
    diff_start          = pack3(start[0], start[1], start[2]);
    diff_dense          = pack3(dense[0], dense[1], dense[2]);
    if (reset === 1'b0) model_step();
    @(posedge clk);
    edge_count++;
    #1;
  endtask

  task automatic chk(string name, logic [63:0] actual, logic [63:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, actual, required);
    end
  endtask

  task automatic rand_vecs();
    for (int i = 0; i < 3; i++) begin
      cost[i]  = rnd16();
      act[i]   = rnd16();
      start[i] = rnd16();
      dense[i] = rnd16();
    end
  endtask

  // Monitor: every strobe must match the oldest expected pop, at its expected edge.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b0) begin
      if (is_update_weight === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pop_unexpected: strobe at edge %0d row %0d, none expected",
                   edge_count, update_weight_row);
        end else begin
          e = exp_q.pop_front();
          if (update_weight_layer !== e.layer || update_weight_row !== e.row ||
              update_weight_value !== e.val || e.cyc != edge_count) begin
            errors++;
            $display("FAIL pop_data: got L%0d R%0d V%h @%0d, expected L%0d R%0d V%h @%0d",
                     update_weight_layer, update_weight_row, update_weight_value, edge_count,
                     e.layer, e.row, e.val, e.cyc);
          end
        end
      end else if (is_update_weight !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL pop_strobe: got %b, expected 0 or 1", is_update_weight);
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= edge_count) begin
        checks++;
        errors++;
        $display("FAIL pop_missing: no strobe at edge %0d, expected row %0d",
                 edge_count, exp_q[0].row);
        exp_q.delete(0);
      end
    end
  end

  initial begin
    reset = 1'b1;
    lr = 0; at = 0; snl = 0; last = 0; rd = 0; layer_in = 0; row_in = 0;
    cost = '{0, 0, 0}; act = '{0, 0, 0}; start = '{0, 0, 0}; dense = '{0, 0, 0};
    m_delta = '{0, 0, 0}; m_err = '{0, 0, 0};
    repeat (3) tick();
    chk("reset_strobe", is_update_weight, 0);
    chk("reset_layer", update_weight_layer, 0);
    chk("reset_value", update_weight_value, 0);
    reset = 1'b0;
    tick();

    // Last-layer seed and a single gradient row
    lr = 128;
    at = 1; snl = 1; last = 1;
    cost = '{256, 512, -256}; act = '{256, 128, 256};
    tick();
    snl = 0; last = 0; layer_in = 2; row_in = 1;
    start = '{512, 1024, -512}; dense = '{0, 0, 0};
    tick();
    at = 0; rd = 1; tick(); rd = 0; tick();
    chk("last_layer_value", update_weight_value, 48'h0100_0200_FF00);
    chk("last_layer_layer", update_weight_layer, 2);
    chk("last_layer_row", update_weight_row, 1);

    // LIFO ordering, also accumulating error for propagation
    at = 1; layer_in = 3;
    row_in = 0; start = '{rnd16(), rnd16(), rnd16()}; dense = '{256, 256, 256}; tick();
    row_in = 1; start = '{rnd16(), rnd16(), rnd16()}; dense = '{0, 0, 0};       tick();
    row_in = 2; start = '{rnd16(), rnd16(), rnd16()}; dense = '{256, 0, 0};     tick();
    at = 0; rd = 1; repeat (3) tick(); rd = 0; tick();
    chk("lifo_last_row", update_weight_row, 0);

    // Propagate accumulated error into the next delta
    at = 1; snl = 1; last = 0; act = '{256, 256, 128}; tick();
    snl = 0; layer_in = 4; row_in = 1; start = '{512, 0, 0}; dense = '{0, 0, 0}; tick();
    at = 0; rd = 1; tick(); rd = 0; tick();
    chk("prop_value", update_weight_value, 48'h0100_0000_0000);

    // Saturation of the delta products
    lr = 256;
    at = 1; snl = 1; last = 1;
    cost = '{s16(16'h7F00), s16(16'h8100), 0}; act = '{512, 512, 0}; tick();
    snl = 0; last = 0; layer_in = 5; start = '{256, 0, 0};
    row_in = 0; tick();
    row_in = 1; tick();
    at = 0; rd = 1; tick(); rd = 0; tick();
    chk("sat_neg_value", update_weight_value, 48'h8000_0000_0000);
    rd = 1; tick(); rd = 0; tick();
    chk("sat_pos_value", update_weight_value, 48'h7FFF_0000_0000);
    rd = 1; tick();
    chk("empty_pop_strobe", is_update_weight, 0);
    rd = 0; tick();

    // Fill past capacity, then push+pop on a full stack, then an out-of-range row
    at = 1; layer_in = 7;
    for (int i = 0; i < 13; i++) begin
      row_in = i % 3;
      start = '{rnd16(), rnd16(), rnd16()};
      tick();
    end
    layer_in = 9; row_in = 0; start = '{rnd16(), rnd16(), rnd16()}; rd = 1; tick();
    rd = 0; row_in = 5; tick();
    at = 0; rd = 1; repeat (13) tick(); rd = 0; tick();
    chk("drain_last_layer", update_weight_layer, 7);
    chk("drain_last_row", update_weight_row, 0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      int sel;
      lr   = rnd16();
      at   = ($urandom_range(0, 3) != 0);
      snl  = ($urandom_range(0, 7) == 0);
      last = $urandom_range(0, 1);
      rd   = ($urandom_range(0, 2) == 0);
      layer_in = $urandom;
      sel = $urandom_range(0, 5);
      row_in = (sel < 4) ? sel : ((sel == 4) ? 5 : 32'h8000_0001);
      rand_vecs();
      tick();
    end
    at = 0; rd = 1; repeat (14) tick(); rd = 0; tick();

    // Asynchronous reset in the middle of a layer with entries still stacked
    lr = 256; at = 1; snl = 1; last = 1;
    cost = '{256, 256, 256}; act = '{256, 256, 256}; tick();
    snl = 0; last = 0; layer_in = 11; start = '{256, 256, 256};
    row_in = 0; tick();
    row_in = 1; tick();
    at = 0; rd = 1; tick(); rd = 0;
    at = 1; row_in = 2; tick(); at = 0;
    #2;
    reset = 1'b1;
    #1;
    stack_m.delete();
    m_delta = '{0, 0, 0}; m_err = '{0, 0, 0};
    chk("midreset_strobe", is_update_weight, 0);
    chk("midreset_layer", update_weight_layer, 0);
    chk("midreset_row", update_weight_row, 0);
    chk("midreset_value", update_weight_value, 0);
    tick(); tick();
    reset = 1'b0;
    rd = 1; tick();
    chk("post_reset_pop", is_update_weight, 0);
    rd = 0; repeat (3) tick();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_pops: %0d expected pops never seen, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
